mem_access_unit: RTL

MEM-stage consumer of the control decoder's memory control bus in the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Turns {SB, SH, LB, LH, Unsigned, MemRead, MemWrite} plus the ALU address into byte-lane requests on a req/ack data-memory port.
- Formats load data with sign or zero extension.
- Stalls the pipeline until memory acknowledges.

---
 rtl/mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit for the 5-stage MIPS pipeline.
//
// Turns the decoder's memory control bus plus the ALU address into a byte-lane
// req/ack request, formats load data (sign/zero extension) and stalls the
// upstream stages until memory acknowledges.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned accesses issue no request; a one-cycle o_misalign
//               entry carrying the faulting address is produced instead.
//   undefined - o_misalign is tied 0; low address bits are dropped.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), synchronous active-low reset
//   i_valid                 EX/MEM entry valid
//   i_ctrl_mem_bus          [SB, SH, LB, LH, Unsigned, BNEQ, Branch, MemRead, MemWrite]
//   i_ctrl_wb_bus           [RegWrite, MemtoReg], forwarded to MEM/WB
//   i_addr, i_store_data    ALU result / effective address, rt store value
//   i_rd_addr               destination register
//   o_mem_req/we/addr/      data-memory request (word-aligned address,
//   wdata/be                lane-replicated data, little-endian byte enables)
//   i_mem_ack, i_mem_rdata  one-cycle completion strobe and read word
//   o_stall                 combinational freeze of IF/ID/EX
//   o_valid, o_ctrl_wb_bus, MEM/WB entry
//   o_result, o_rd_addr
//   o_misalign              misaligned-access flag
module mem_access_unit #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned NB_CTRL_M  = 9,
  parameter int unsigned NB_CTRL_WB = 2,
  parameter int unsigned NB_REG     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_DATA-1:0]    i_addr,
  input  logic [NB_DATA-1:0]    i_store_data,
  input  logic [NB_REG-1:0]     i_rd_addr,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [NB_DATA-1:0]    o_mem_addr,
  output logic [NB_DATA-1:0]    o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ack,
  input  logic [NB_DATA-1:0]    i_mem_rdata,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_DATA-1:0]    o_result,
  output logic [NB_REG-1:0]     o_rd_addr,
  output logic                  o_misalign
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam int unsigned CTRL_SB    = 8;
  localparam int unsigned CTRL_SH    = 7;
  localparam int unsigned CTRL_LB    = 6;
  localparam int unsigned CTRL_LH    = 5;
  localparam int unsigned CTRL_UNS   = 4;
  localparam int unsigned CTRL_READ  = 1;
  localparam int unsigned CTRL_WRITE = 0;

  // Branch bits belong to the EX stage; they are deliberately not consumed here.
  logic unused_branch_bits;
  assign unused_branch_bits = ^i_ctrl_mem_bus[3:2];

  logic ctrl_sb, ctrl_sh, ctrl_lb, ctrl_lh, ctrl_uns, ctrl_rd, ctrl_wr;
  assign ctrl_sb  = i_ctrl_mem_bus[CTRL_SB];
  assign ctrl_sh  = i_ctrl_mem_bus[CTRL_SH];
  assign ctrl_lb  = i_ctrl_mem_bus[CTRL_LB];
  assign ctrl_lh  = i_ctrl_mem_bus[CTRL_LH];
  assign ctrl_uns = i_ctrl_mem_bus[CTRL_UNS];
  assign ctrl_rd  = i_ctrl_mem_bus[CTRL_READ];
  assign ctrl_wr  = i_ctrl_mem_bus[CTRL_WRITE];

  logic access;
  assign access = i_valid & (ctrl_rd | ctrl_wr);

  // State and request fields
  logic [0:0]            state_q, state_d;
  logic [NB_DATA-1:0]    addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [NB_DATA-1:0]    wdata_q, wdata_d;
  logic                  load_q, load_d;
  logic                  lb_q, lb_d;
  logic                  lh_q, lh_d;
  logic                  uns_q, uns_d;
  logic [NB_CTRL_WB-1:0] pend_wb_q, pend_wb_d;
  logic [NB_REG-1:0]     pend_rd_q, pend_rd_d;

  // MEM/WB outputs
  logic                  valid_q, valid_d;
  logic [NB_CTRL_WB-1:0] wb_q, wb_d;
  logic [NB_DATA-1:0]    result_q, result_d;
  logic [NB_REG-1:0]     rd_q, rd_d;

  // Store lane selection; SB takes priority over SH, reads enable all lanes.
  logic [3:0]         be_new;
  logic [NB_DATA-1:0] wdata_new;
  always_comb begin
    if (ctrl_sb) begin
      be_new    = 4'b0001 << i_addr[1:0];
      wdata_new = {4{i_store_data[7:0]}};
    end else if (ctrl_sh) begin
      be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{i_store_data[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = i_store_data;
    end
    if (!ctrl_wr) begin
      be_new = 4'b1111;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  always_comb begin
    if (ctrl_wr) begin
      misaligned = ctrl_sb ? 1'b0 : (ctrl_sh ? i_addr[0] : (i_addr[1:0] != 2'b00));
    end else begin
      misaligned = ctrl_lb ? 1'b0 : (ctrl_lh ? i_addr[0] : (i_addr[1:0] != 2'b00));
    end
  end
`endif

  // Load formatting from the latched address and size/sign fields.
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [NB_DATA-1:0] load_fmt;
  always_comb begin
    lane_byte = i_mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_byte = i_mem_rdata[15:8];
      2'd2:    lane_byte = i_mem_rdata[23:16];
      2'd3:    lane_byte = i_mem_rdata[31:24];
      default: lane_byte = i_mem_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    if (lb_q) begin
      load_fmt = {{(NB_DATA-8){lane_byte[7] & ~uns_q}}, lane_byte};
    end else if (lh_q) begin
      load_fmt = {{(NB_DATA-16){lane_half[15] & ~uns_q}}, lane_half};
    end else begin
      load_fmt = i_mem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    lb_d      = lb_q;
    lh_d      = lh_q;
    uns_d     = uns_q;
    pend_wb_d = pend_wb_q;
    pend_rd_d = pend_rd_q;
    valid_d   = 1'b0;
    wb_d      = wb_q;
    result_d  = result_q;
    rd_d      = rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            // Trap entry: no request, register write suppressed.
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            wb_d       = '0;
            result_d   = i_addr;
            rd_d       = i_rd_addr;
          end else
`endif
          begin
            state_d   = ST_REQ;
            addr_d    = i_addr;
            we_d      = ctrl_wr;
            be_d      = be_new;
            wdata_d   = wdata_new;
            load_d    = ~ctrl_wr;
            lb_d      = ctrl_lb;
            lh_d      = ctrl_lh;
            uns_d     = ctrl_uns;
            pend_wb_d = i_ctrl_wb_bus;
            pend_rd_d = i_rd_addr;
          end
        end else if (i_valid) begin
          valid_d  = 1'b1;
          wb_d     = i_ctrl_wb_bus;
          result_d = i_addr;
          rd_d     = i_rd_addr;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          wb_d     = pend_wb_q;
          rd_d     = pend_rd_q;
          result_d = load_q ? load_fmt : addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      load_q    <= 1'b0;
      lb_q      <= 1'b0;
      lh_q      <= 1'b0;
      uns_q     <= 1'b0;
      pend_wb_q <= '0;
      pend_rd_q <= '0;
      valid_q   <= 1'b0;
      wb_q      <= '0;
      result_q  <= '0;
      rd_q      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      lb_q      <= lb_d;
      lh_q      <= lh_d;
      uns_q     <= uns_d;
      pend_wb_q <= pend_wb_d;
      pend_rd_q <= pend_rd_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign o_mem_req     = (state_q == ST_REQ);
  assign o_mem_we      = we_q;
  assign o_mem_addr    = {addr_q[NB_DATA-1:2], 2'b00};
  assign o_mem_wdata   = wdata_q;
  assign o_mem_be      = be_q;
  assign o_stall       = i_rst & ((state_q == ST_REQ) | access);
  assign o_valid       = valid_q;
  assign o_ctrl_wb_bus = wb_q;
  assign o_result      = result_q;
  assign o_rd_addr     = rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign o_misalign    = misalign_q;
`else
  assign o_misalign    = 1'b0;
`endif

endmodule
